// File: rtl/vx_smem_responder_if.sv
// ============================================================================
// Module      : vx_smem_responder_if
// Description : Batched multi-lane request / gathered response bus between the
//               memory path (master) and the shared-memory responder (slave).
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface vx_smem_responder_if #(
  parameter int NUM_REQS   = 4,
  parameter int WORD_SIZE  = 4,
  parameter int TAG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 30
);
  logic [NUM_REQS-1:0]             req_valid;
  logic                            req_rw;
  logic [NUM_REQS*WORD_SIZE-1:0]   req_byteen;
  logic [NUM_REQS*ADDR_WIDTH-1:0]  req_addr;
  logic [NUM_REQS*8*WORD_SIZE-1:0] req_data;
  logic [NUM_REQS*TAG_WIDTH-1:0]   req_tag;
  logic                            req_ready;

  logic                            rsp_valid;
  logic [NUM_REQS-1:0]             rsp_tmask;
  logic [TAG_WIDTH-1:0]            rsp_tag;
  logic [NUM_REQS*8*WORD_SIZE-1:0] rsp_data;
  logic                            rsp_ready;

  modport master (
    output req_valid, req_rw, req_byteen, req_addr, req_data, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_tmask, rsp_tag, rsp_data,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_rw, req_byteen, req_addr, req_data, req_tag,
    output req_ready,
    output rsp_valid, rsp_tmask, rsp_tag, rsp_data,
    input  rsp_ready
  );
endinterface

`default_nettype wire

// File: rtl/vx_smem_responder.sv
// ============================================================================
// Module      : vx_smem_responder
// Description : Banked scratchpad responder; serializes bank conflicts within a
//               batch and returns one gathered read response per read batch.
//               Optional macro SMEM_PERF_EN adds the perf_bank_stalls counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module vx_smem_responder #(
  parameter int NUM_REQS   = 4,
  parameter int WORD_SIZE  = 4,
  parameter int TAG_WIDTH  = 8,
  parameter int BANK_WORDS = 256,
  parameter int ADDR_WIDTH = 30
) (
  input  logic               clk,
  input  logic               reset,
  vx_smem_responder_if.slave bus
`ifdef SMEM_PERF_EN
  ,
  output logic [43:0]        perf_bank_stalls
`endif
);

  localparam int c_BANK_BITS = $clog2(NUM_REQS);
  localparam int c_ROW_BITS  = $clog2(BANK_WORDS);
  localparam int c_WORD_W    = 8 * WORD_SIZE;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  state_t r_state, w_state_next;

  logic                                 r_rw;
  logic [NUM_REQS-1:0]                  r_valid;
  logic [NUM_REQS-1:0]                  r_pending;
  logic [NUM_REQS-1:0][c_BANK_BITS-1:0] r_bank;
  logic [NUM_REQS-1:0][c_ROW_BITS-1:0]  r_row;
  logic [NUM_REQS-1:0][WORD_SIZE-1:0]   r_byteen;
  logic [NUM_REQS-1:0][c_WORD_W-1:0]    r_wdata;
  logic [NUM_REQS-1:0][c_WORD_W-1:0]    r_lane_data;
  logic [TAG_WIDTH-1:0]                 r_tag;

  logic                                 r_rsp_valid;
  logic [NUM_REQS-1:0]                  r_rsp_tmask;
  logic [TAG_WIDTH-1:0]                 r_rsp_tag;
  logic [NUM_REQS-1:0][c_WORD_W-1:0]    r_rsp_data;

  logic [c_WORD_W-1:0] r_mem [NUM_REQS][BANK_WORDS];

  logic [NUM_REQS-1:0]               w_grant;
  logic [NUM_REQS-1:0][c_WORD_W-1:0] w_rd_word;
  logic [NUM_REQS-1:0][c_WORD_W-1:0] w_rsp_word;
  logic [TAG_WIDTH-1:0]              w_first_tag;
  logic                              w_req_ready;
  logic                              w_fire;
  logic                              w_last;

  // Ready is forced low while reset is held, independent of the state flops.
  assign w_req_ready = reset && (r_state == ST_IDLE) && !r_rsp_valid;
  assign w_fire      = w_req_ready && (|bus.req_valid);
  assign w_last      = (r_state == ST_SERVE) && ((r_pending & ~w_grant) == '0);

  // Each bank serves the lowest-index pending lane that targets it.
  always_comb begin
    w_grant = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_grant[i] = r_pending[i] && (r_state == ST_SERVE);
      for (int j = 0; j < i; j++) begin
        if (r_pending[j] && (r_bank[j] == r_bank[i])) begin
          w_grant[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_first_tag = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        w_first_tag = bus.req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_REQS; g++) begin : g_lane
      assign w_rd_word[g]  = r_mem[r_bank[g]][r_row[g]];
      assign w_rsp_word[g] = !r_valid[g] ? '0 :
                             (w_grant[g] ? w_rd_word[g] : r_lane_data[g]);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_fire) w_state_next = ST_SERVE;
      ST_SERVE: if (w_last) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rw        <= 1'b0;
      r_valid     <= '0;
      r_pending   <= '0;
      r_bank      <= '0;
      r_row       <= '0;
      r_byteen    <= '0;
      r_wdata     <= '0;
      r_lane_data <= '0;
      r_tag       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_tmask <= '0;
      r_rsp_tag   <= '0;
      r_rsp_data  <= '0;
    end else begin
      if (w_fire) begin
        r_rw      <= bus.req_rw;
        r_valid   <= bus.req_valid;
        r_pending <= bus.req_valid;
        r_tag     <= w_first_tag;
        for (int i = 0; i < NUM_REQS; i++) begin
          r_bank[i]   <= bus.req_addr[i*ADDR_WIDTH +: c_BANK_BITS];
          r_row[i]    <= bus.req_addr[i*ADDR_WIDTH + c_BANK_BITS +: c_ROW_BITS];
          r_byteen[i] <= bus.req_byteen[i*WORD_SIZE +: WORD_SIZE];
          r_wdata[i]  <= bus.req_data[i*c_WORD_W +: c_WORD_W];
        end
      end else if (r_state == ST_SERVE) begin
        r_pending <= r_pending & ~w_grant;
        for (int i = 0; i < NUM_REQS; i++) begin
          if (w_grant[i] && !r_rw) begin
            r_lane_data[i] <= w_rd_word[i];
          end
        end
      end

      if (w_last && !r_rw) begin
        r_rsp_valid <= 1'b1;
        r_rsp_tmask <= r_valid;
        r_rsp_tag   <= r_tag;
        r_rsp_data  <= w_rsp_word;
      end else if (r_rsp_valid && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQS; i++) begin
      if (w_grant[i] && r_rw) begin
        for (int b = 0; b < WORD_SIZE; b++) begin
          if (r_byteen[i][b]) begin
            r_mem[r_bank[i]][r_row[i]][b*8 +: 8] <= r_wdata[i][b*8 +: 8];
          end
        end
      end
    end
  end

`ifdef SMEM_PERF_EN
  logic [43:0] r_perf_bank_stalls;
  logic        r_first_serve;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_bank_stalls <= '0;
      r_first_serve      <= 1'b0;
    end else begin
      if (w_fire) begin
        r_first_serve <= 1'b1;
      end else if (r_state == ST_SERVE) begin
        r_first_serve <= 1'b0;
        if (!r_first_serve) begin
          r_perf_bank_stalls <= r_perf_bank_stalls + 44'd1;
        end
      end
    end
  end

  assign perf_bank_stalls = r_perf_bank_stalls;
`endif

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_tmask = r_rsp_tmask;
  assign bus.rsp_tag   = r_rsp_tag;
  assign bus.rsp_data  = r_rsp_data;

endmodule

`default_nettype wire

// File: tb/tb_vx_smem_responder.sv
// ============================================================================
// Module      : tb_vx_smem_responder
// Description : Directed self-checking bench for vx_smem_responder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_vx_smem_responder;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  vx_smem_responder_if #(.NUM_REQS(4), .WORD_SIZE(4), .TAG_WIDTH(8), .ADDR_WIDTH(30)) bus ();

`ifdef SMEM_PERF_EN
  logic [43:0] perf;
`endif

  vx_smem_responder #(
    .NUM_REQS(4), .WORD_SIZE(4), .TAG_WIDTH(8), .BANK_WORDS(256), .ADDR_WIDTH(30)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef SMEM_PERF_EN
    ,
    .perf_bank_stalls (perf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_lanes();
    bus.req_valid  = '0;
    bus.req_rw     = 1'b0;
    bus.req_byteen = '0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.req_tag    = '0;
  endtask

  task automatic set_lane(input int i, input logic [29:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic [7:0] t);
    bus.req_addr[i*30 +: 30] = a;
    bus.req_data[i*32 +: 32] = d;
    bus.req_byteen[i*4 +: 4] = be;
    bus.req_tag[i*8 +: 8]    = t;
  endtask

  // Presents a batch for one clock edge; reports whether ready was high.
  task automatic issue(input logic rw, input logic [3:0] v, output logic was_ready);
    bus.req_rw    = rw;
    bus.req_valid = v;
    was_ready     = bus.req_ready;
    @(posedge clk); #1;
    bus.req_valid = '0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (!bus.req_ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b want 0", bus.req_ready);
    else n_pass++;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_tmask, bus.rsp_tag} !== 13'd0 || bus.rsp_data !== 128'd0)
      $display("FAIL rst_rsp: valid=%b tmask=%b tag=%h data=%h want all 0",
               bus.rsp_valid, bus.rsp_tmask, bus.rsp_tag, bus.rsp_data);
    else n_pass++;
`ifdef SMEM_PERF_EN
    n_checks++;
    if (perf !== 44'd0) $display("FAIL rst_perf: got %0d want 0", perf);
    else n_pass++;
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", bus.req_ready);
    else n_pass++;
  endtask

  task automatic test_write_read();
    logic rdy;
    int   lat;
    logic [31:0] exp_d [4];
    exp_d = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    clear_lanes();
    for (int i = 0; i < 4; i++) set_lane(i, 30'(i), exp_d[i], 4'hF, 8'(8'h20 + i));
    issue(1'b1, 4'hF, rdy);
    n_checks++;
    if (rdy !== 1'b1 || bus.req_ready !== 1'b0)
      $display("FAIL wr_handshake: ready_before=%b ready_after=%b want 1/0", rdy, bus.req_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
      $display("FAIL wr_done: req_ready=%b rsp_valid=%b want 1/0", bus.req_ready, bus.rsp_valid);
    else n_pass++;

    clear_lanes();
    for (int i = 0; i < 4; i++) set_lane(i, 30'(i), 32'hDEADBEEF, 4'hF, 8'(8'h30 + i));
    issue(1'b0, 4'hF, rdy);
    wait_rsp(lat);
    n_checks++;
    if (rdy !== 1'b1 || lat !== 1) $display("FAIL rd_latency: ready=%b lat=%0d want 1/1", rdy, lat);
    else n_pass++;
    n_checks++;
    if (bus.rsp_tmask !== 4'hF || bus.rsp_tag !== 8'h30)
      $display("FAIL rd_tmask_tag: tmask=%b tag=%h want 1111/30", bus.rsp_tmask, bus.rsp_tag);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.rsp_data[i*32 +: 32] !== exp_d[i])
        $display("FAIL rd_data lane%0d: got %h want %h", i, bus.rsp_data[i*32 +: 32], exp_d[i]);
      else n_pass++;
    end
    consume();
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL rd_dequeue: rsp_valid=%b req_ready=%b want 0/1", bus.rsp_valid, bus.req_ready);
    else n_pass++;
  endtask

  task automatic test_bank_conflict();
    logic rdy;
    int   lat;
    logic [31:0] exp_d [4];
    exp_d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    clear_lanes();
    for (int i = 0; i < 4; i++) set_lane(i, 30'(4 * i), exp_d[i], 4'hF, 8'h00);
    issue(1'b1, 4'hF, rdy);
    wait_ready(lat);
    n_checks++;
    if (rdy !== 1'b1 || lat !== 4) $display("FAIL conf_wr_busy: ready=%b cycles=%0d want 1/4", rdy, lat);
    else n_pass++;

    clear_lanes();
    for (int i = 0; i < 4; i++) set_lane(i, 30'(4 * i), 32'h0, 4'h0, 8'(8'h40 + i));
    issue(1'b0, 4'hF, rdy);
    wait_rsp(lat);
    n_checks++;
    if (lat !== 4) $display("FAIL conf_rd_latency: got %0d want 4", lat);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.rsp_data[i*32 +: 32] !== exp_d[i])
        $display("FAIL conf_rd_data lane%0d: got %h want %h", i, bus.rsp_data[i*32 +: 32], exp_d[i]);
      else n_pass++;
    end
`ifdef SMEM_PERF_EN
    n_checks++;
    if (perf !== 44'd6) $display("FAIL conf_perf: got %0d want 6", perf);
    else n_pass++;
`endif
    consume();
  endtask

  task automatic test_partial_write();
    logic rdy;
    int   lat;
    clear_lanes();
    set_lane(0, 30'd5, 32'hFFFFFFFF, 4'hF, 8'h00);
    issue(1'b1, 4'b0001, rdy);
    wait_ready(lat);
    set_lane(0, 30'd5, 32'h12345678, 4'b0011, 8'h00);
    issue(1'b1, 4'b0001, rdy);
    wait_ready(lat);
    clear_lanes();
    set_lane(0, 30'd5, 32'h0, 4'h0, 8'h55);
    set_lane(1, 30'd1, 32'h0, 4'h0, 8'h66);
    issue(1'b0, 4'b0001, rdy);
    wait_rsp(lat);
    n_checks++;
    if (bus.rsp_tmask !== 4'b0001 || bus.rsp_tag !== 8'h55)
      $display("FAIL pw_tmask_tag: tmask=%b tag=%h want 0001/55", bus.rsp_tmask, bus.rsp_tag);
    else n_pass++;
    n_checks++;
    if (bus.rsp_data !== {96'd0, 32'hFFFF5678})
      $display("FAIL pw_data: got %h want %h", bus.rsp_data, {96'd0, 32'hFFFF5678});
    else n_pass++;
    consume();
  endtask

  task automatic test_same_addr();
    logic rdy;
    int   lat;
    clear_lanes();
    set_lane(1, 30'd8, 32'hB1, 4'hF, 8'h00);
    set_lane(3, 30'd8, 32'hB3, 4'hF, 8'h00);
    issue(1'b1, 4'b1010, rdy);
    wait_ready(lat);
    n_checks++;
    if (lat !== 2) $display("FAIL same_wr_busy: cycles=%0d want 2", lat);
    else n_pass++;

    clear_lanes();
    set_lane(0, 30'd8, 32'h0, 4'h0, 8'h71);
    set_lane(1, 30'd2, 32'h0, 4'h0, 8'h72);
    set_lane(2, 30'd1, 32'h0, 4'h0, 8'h73);
    set_lane(3, 30'd3, 32'h0, 4'h0, 8'h74);
    issue(1'b0, 4'b0101, rdy);
    wait_rsp(lat);
    n_checks++;
    if (lat !== 1 || bus.rsp_tmask !== 4'b0101 || bus.rsp_tag !== 8'h71)
      $display("FAIL sparse_hdr: lat=%0d tmask=%b tag=%h want 1/0101/71", lat, bus.rsp_tmask, bus.rsp_tag);
    else n_pass++;
    n_checks++;
    if (bus.rsp_data !== {32'h0, 32'h22222222, 32'h0, 32'h000000B3})
      $display("FAIL sparse_data: got %h want %h", bus.rsp_data,
               {32'h0, 32'h22222222, 32'h0, 32'h000000B3});
    else n_pass++;
    consume();
  endtask

  task automatic test_backpressure();
    logic rdy;
    int   lat;
    int   bad;
    logic [127:0] exp_data;
    exp_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h000000A0};
    clear_lanes();
    for (int i = 0; i < 4; i++) set_lane(i, 30'(i), 32'h0, 4'h0, 8'(8'h90 + i));
    issue(1'b0, 4'hF, rdy);
    wait_rsp(lat);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = 4'hF;
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_tmask !== 4'hF || bus.rsp_tag !== 8'h90 ||
          bus.rsp_data !== exp_data || bus.req_ready !== 1'b0) bad++;
    end
    bus.req_valid = '0;
    n_checks++;
    if (bad != 0)
      $display("FAIL bp_hold: %0d unstable cycles, last valid=%b tag=%h data=%h ready=%b want 1/90/%h/0",
               bad, bus.rsp_valid, bus.rsp_tag, bus.rsp_data, bus.req_ready, exp_data);
    else n_pass++;
    consume();
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL bp_release: rsp_valid=%b req_ready=%b want 0/1", bus.rsp_valid, bus.req_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid_serve();
    logic rdy;
    int   lat;
    logic [31:0] exp_d [4];
    exp_d = '{32'hA0, 32'hA1, 32'hB3, 32'hA3};
    clear_lanes();
    for (int i = 0; i < 4; i++) set_lane(i, 30'(4 * i), 32'h0, 4'h0, 8'(8'hC0 + i));
    issue(1'b0, 4'hF, rdy);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0)
      $display("FAIL mid_rst_hold: req_ready=%b rsp_valid=%b want 0/0", bus.req_ready, bus.rsp_valid);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
      $display("FAIL mid_rst_release: req_ready=%b rsp_valid=%b want 1/0", bus.req_ready, bus.rsp_valid);
    else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL mid_rst_dropped: rsp_valid=%b want 0", bus.rsp_valid);
    else n_pass++;

    issue(1'b0, 4'hF, rdy);
    wait_rsp(lat);
    n_checks++;
    if (lat !== 4 || bus.rsp_tag !== 8'hC0)
      $display("FAIL post_rst_rd: lat=%0d tag=%h want 4/c0", lat, bus.rsp_tag);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.rsp_data[i*32 +: 32] !== exp_d[i])
        $display("FAIL post_rst_data lane%0d: got %h want %h", i, bus.rsp_data[i*32 +: 32], exp_d[i]);
      else n_pass++;
    end
`ifdef SMEM_PERF_EN
    n_checks++;
    if (perf !== 44'd3) $display("FAIL post_rst_perf: got %0d want 3", perf);
    else n_pass++;
`endif
    consume();
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b0;
    bus.rsp_ready = 1'b0;
    clear_lanes();
    test_reset();
    test_write_read();
    test_bank_conflict();
    test_partial_write();
    test_same_addr();
    test_backpressure();
    test_reset_mid_serve();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
